// File: rtl/p23_bus_access_unit.sv
// p23_bus_access_unit: single-outstanding valid/ready bus sequencer
// with a wait-cycle timeout that turns a hung slave into a bus fault.
module p23_bus_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic        req_instr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        req_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] fault_addr,
  output logic        fault_instr,
  output logic        busy,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_instr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACT  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST =
    16'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [31:0] faddr_q, faddr_d;
  logic        finstr_q, finstr_d;

  logic st_idle, st_act, st_resp;

  assign st_idle = (state_q == S_IDLE);
  assign st_act  = (state_q == S_ACT);
  assign st_resp = (state_q == S_RESP);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    instr_d  = instr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;
    faddr_d  = faddr_q;
    finstr_d = finstr_q;
    unique case (1'b1)
      st_idle: begin
        if (req_valid) begin
          instr_d = req_instr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          cnt_d   = '0;
          state_d = S_ACT;
        end
      end
      st_act: begin
        // a completing slave beats a timeout firing in the same cycle
        if (bus_ready) begin
          if (wstrb_q == 4'b0000) rdata_d = bus_rdata;
          fault_d = 1'b0;
          state_d = S_RESP;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          fault_d  = 1'b1;
          rdata_d  = '0;
          faddr_d  = addr_q;
          finstr_d = instr_q;
          state_d  = S_RESP;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      st_resp: begin
        fault_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      instr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
      faddr_q  <= '0;
      finstr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      instr_q  <= instr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
      faddr_q  <= faddr_d;
      finstr_q <= finstr_d;
    end
  end

  assign req_ready   = st_resp;
  assign busy        = st_act | st_resp;
  assign bus_valid   = st_act;
  assign rsp_rdata   = rdata_q;
  assign rsp_fault   = fault_q;
  assign fault_addr  = faddr_q;
  assign fault_instr = finstr_q;
  assign bus_instr   = instr_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_wstrb   = wstrb_q;

endmodule

// File: tb/tb_p23_bus_access_unit.sv
// tb_p23_bus_access_unit: randomized bench for the bus access unit,
// two instances (timeout 8 and timeout disabled) against a txn model.
module tb_p23_bus_access_unit;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_instr = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;

  logic        a_rr, a_flt, a_fi, a_busy, a_bv, a_bi;
  logic [31:0] a_rd, a_fa, a_ba, a_bw;
  logic [3:0]  a_bs;
  logic        b_rr, b_flt, b_fi, b_busy, b_bv, b_bi;
  logic [31:0] b_rd, b_fa, b_ba, b_bw;
  logic [3:0]  b_bs;

  p23_bus_access_unit #(.TIMEOUT_CYCLES(8)) u_a (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid & ~sel), .req_instr(req_instr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_ready(a_rr),
    .rsp_rdata(a_rd), .rsp_fault(a_flt),
    .fault_addr(a_fa), .fault_instr(a_fi), .busy(a_busy),
    .bus_valid(a_bv), .bus_ready(bus_ready), .bus_instr(a_bi),
    .bus_addr(a_ba), .bus_wdata(a_bw), .bus_wstrb(a_bs),
    .bus_rdata(bus_rdata)
  );

  p23_bus_access_unit #(.TIMEOUT_CYCLES(0)) u_b (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid & sel), .req_instr(req_instr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_ready(b_rr),
    .rsp_rdata(b_rd), .rsp_fault(b_flt),
    .fault_addr(b_fa), .fault_instr(b_fi), .busy(b_busy),
    .bus_valid(b_bv), .bus_ready(bus_ready), .bus_instr(b_bi),
    .bus_addr(b_ba), .bus_wdata(b_bw), .bus_wstrb(b_bs),
    .bus_rdata(bus_rdata)
  );

  logic        d_rr, d_flt, d_fi, d_busy, d_bv, d_bi;
  logic [31:0] d_rd, d_fa, d_ba, d_bw;
  logic [3:0]  d_bs;

  assign d_rr   = sel ? b_rr   : a_rr;
  assign d_flt  = sel ? b_flt  : a_flt;
  assign d_fi   = sel ? b_fi   : a_fi;
  assign d_busy = sel ? b_busy : a_busy;
  assign d_bv   = sel ? b_bv   : a_bv;
  assign d_bi   = sel ? b_bi   : a_bi;
  assign d_rd   = sel ? b_rd   : a_rd;
  assign d_fa   = sel ? b_fa   : a_fa;
  assign d_ba   = sel ? b_ba   : a_ba;
  assign d_bw   = sel ? b_bw   : a_bw;
  assign d_bs   = sel ? b_bs   : a_bs;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cur_t = 8;
  always @(posedge clk) cyc <= cyc + 1;

  // transaction-level model: one outstanding txn plus committed results
  bit          live = 1'b0;
  int          acc = 0;
  int          act_len = 0;
  bit          t_fault = 1'b0;
  logic [31:0] t_addr = '0;
  logic [3:0]  t_wstrb = '0;
  logic        t_instr = 1'b0;
  logic [31:0] t_rd = '0;
  logic [31:0] m_ba = '0, m_bw = '0, m_rdata = '0, m_faddr = '0;
  logic [3:0]  m_bs = '0;
  logic        m_bi = 1'b0, m_finstr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    live = 1'b0;
    m_ba = '0; m_bw = '0; m_bs = '0; m_bi = 1'b0;
    m_rdata = '0; m_faddr = '0; m_finstr = 1'b0;
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic ins,
                        input int w);
    live    = 1'b1;
    acc     = cyc;
    t_addr  = a;
    t_wstrb = ws;
    t_instr = ins;
    t_fault = (cur_t != 0) && (w >= cur_t);
    act_len = t_fault ? cur_t : w + 1;
    m_ba = a; m_bw = wd; m_bs = ws; m_bi = ins;
  endtask

  always @(negedge clk) begin
    bit act, rsp;
    act = live && cyc >= acc && cyc < acc + act_len;
    rsp = live && cyc == acc + act_len;
    if (rsp) begin
      if (t_fault) begin
        m_rdata  = '0;
        m_faddr  = t_addr;
        m_finstr = t_instr;
      end else if (t_wstrb == 4'b0000) begin
        m_rdata = t_rd;
      end
    end
    chk("req_ready", 32'(d_rr), 32'(rsp));
    chk("bus_valid", 32'(d_bv), 32'(act));
    chk("busy", 32'(d_busy), 32'(act | rsp));
    chk("rsp_fault", 32'(d_flt), 32'(rsp & t_fault));
    chk("rsp_rdata", d_rd, m_rdata);
    chk("fault_addr", d_fa, m_faddr);
    chk("fault_instr", 32'(d_fi), 32'(m_finstr));
    chk("bus_addr", d_ba, m_ba);
    chk("bus_wdata", d_bw, m_bw);
    chk("bus_wstrb", 32'(d_bs), 32'(m_bs));
    chk("bus_instr", 32'(d_bi), 32'(m_bi));
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus_ready = 1'($urandom);
      bus_rdata = $urandom;
      req_addr  = $urandom;
      req_instr = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic txn(input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input logic ins,
                     input int w, input logic [31:0] rdv,
                     output int vcnt, output int rcyc,
                     output logic [31:0] ba0, output logic [31:0] rd,
                     output logic rr, output logic flt);
    req_valid = 1'b1;
    req_addr  = a;
    req_wdata = wd;
    req_wstrb = ws;
    req_instr = ins;
    bus_ready = 1'($urandom);
    bus_rdata = $urandom;
    @(posedge clk); #1;
    accept(a, wd, ws, ins, w);
    vcnt = 0;
    ba0  = d_ba;
    for (int k = 0; k < act_len; k++) begin
      vcnt += int'(d_bv);
      bus_ready = (k == w);
      bus_rdata = (k == w) ? rdv : $urandom;
      if (k == w) t_rd = rdv;
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_wstrb = 4'($urandom);
      req_instr = 1'($urandom);
      @(posedge clk); #1;
    end
    vcnt += int'(d_bv);
    rcyc = cyc;
    rd   = d_rd;
    rr   = d_rr;
    flt  = d_flt;
    bus_ready = 1'($urandom);
    bus_rdata = $urandom;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    int vc, rc, rc2, w;
    logic [31:0] ba, rd;
    logic rr, fl;
    model_reset();
    repeat (4) begin
      req_valid = 1'($urandom);
      req_addr  = $urandom;
      req_wstrb = 4'($urandom);
      bus_ready = 1'($urandom);
      bus_rdata = $urandom;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    resetn = 1'b1;
    idle(2);

    txn(32'h0000_1004, 32'h0, 4'b0000, 1'b0, 0, 32'hDEAD_BEEF,
        vc, rc, ba, rd, rr, fl);
    chk("zw_bus_addr", ba, 32'h0000_1004);
    chk("zw_rdata", rd, 32'hDEAD_BEEF);
    chk("zw_ready", 32'(rr), 32'd1);
    chk("zw_fault", 32'(fl), 32'd0);
    chk("zw_valid_cycles", 32'(vc), 32'd1);
    idle(1);

    txn(32'h0000_2000, 32'h0000_A5A5, 4'b0011, 1'b0, 3, $urandom,
        vc, rc, ba, rd, rr, fl);
    chk("ws_rdata_kept", rd, 32'hDEAD_BEEF);
    chk("ws_valid_cycles", 32'(vc), 32'd4);
    chk("ws_ready", 32'(rr), 32'd1);
    idle(2);

    txn(32'h8000_0000, $urandom, 4'b0000, 1'b1, 100, $urandom,
        vc, rc, ba, rd, rr, fl);
    chk("to_valid_cycles", 32'(vc), 32'd8);
    chk("to_fault", 32'(fl), 32'd1);
    chk("to_ready", 32'(rr), 32'd1);
    chk("to_rdata", rd, 32'd0);
    chk("to_fault_addr", d_fa, 32'h8000_0000);
    chk("to_fault_instr", 32'(d_fi), 32'd1);
    idle(1);

    txn(32'h0000_4000, 32'h0, 4'b0000, 1'b0, 7, 32'h1234_5678,
        vc, rc, ba, rd, rr, fl);
    chk("edge_fault", 32'(fl), 32'd0);
    chk("edge_rdata", rd, 32'h1234_5678);
    chk("edge_valid_cycles", 32'(vc), 32'd8);

    txn(32'h0000_5000, 32'h0, 4'b0000, 1'b0, 0, $urandom,
        vc, rc, ba, rd, rr, fl);
    txn(32'h0000_5004, 32'h0, 4'b0000, 1'b0, 0, $urandom,
        vc, rc2, ba, rd, rr, fl);
    chk("b2b_gap", 32'(rc2 - rc), 32'd3);
    idle(2);

    repeat (60) begin
      w = ($urandom % 4 == 0) ? $urandom_range(5, 12)
                              : $urandom_range(0, 3);
      txn($urandom, $urandom, 4'($urandom), 1'($urandom), w,
          $urandom, vc, rc, ba, rd, rr, fl);
      if ($urandom % 2 == 1) idle($urandom_range(1, 3));
    end

    bus_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h0000_3000;
    req_wdata = 32'h0;
    req_wstrb = 4'b0000;
    req_instr = 1'b0;
    @(posedge clk); #1;
    accept(32'h0000_3000, 32'h0, 4'b0000, 1'b0, 50);
    @(posedge clk); #1;
    resetn = 1'b0;
    model_reset();
    #1;
    chk("rst_bus_valid", 32'(d_bv), 32'd0);
    chk("rst_busy", 32'(d_busy), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    resetn = 1'b1;
    idle(12);

    resetn = 1'b0;
    model_reset();
    @(posedge clk); #1;
    sel = 1'b1;
    cur_t = 0;
    resetn = 1'b1;
    idle(2);
    txn(32'h0000_6000, 32'h0, 4'b0000, 1'b0, 1000, 32'hCAFE_F00D,
        vc, rc, ba, rd, rr, fl);
    chk("nt_fault", 32'(fl), 32'd0);
    chk("nt_rdata", rd, 32'hCAFE_F00D);
    chk("nt_valid_cycles", 32'(vc), 32'd1001);
    repeat (10) begin
      txn($urandom, $urandom, 4'($urandom), 1'($urandom),
          $urandom_range(0, 12), $urandom, vc, rc, ba, rd, rr, fl);
      idle($urandom_range(0, 2));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
